// File: rtl/gpio_led_module.sv
// gpio_led_module: self-timed LED progress sequencer showing clock/reset are alive
module gpio_led_module #(
    parameter int PRESCALE = 10
) (
    input  logic clk,
    input  logic rst,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4,
    output logic led_done
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_L3, S_L4, S_DONE} state_t;
    logic [CW-1:0] cnt;
    logic tick;
    state_t state, nxt;
    assign tick = cnt == LAST;
    // free-running prescaler, wraps after PRESCALE-1
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    // one step per tick, DONE is terminal, unused encodings fall back to IDLE
    always_comb
        nxt = state > S_DONE ? S_IDLE :
              (state == S_DONE || !tick) ? state : state_t'(state + 3'd1);
    // state and outputs decoded from the next state so LEDs change on the same edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= S_IDLE;
            led1     <= 1'b0;
            led2     <= 1'b0;
            led3     <= 1'b0;
            led4     <= 1'b0;
            led_done <= 1'b0;
        end else begin
            state    <= nxt;
            led1     <= nxt >= S_L1;
            led2     <= nxt >= S_L2;
            led3     <= nxt >= S_L3;
            led4     <= nxt >= S_L4;
            led_done <= nxt == S_DONE;
        end
endmodule

// File: tb/tb_gpio_led_module.sv
// tb_gpio_led_module: checks sequencer timing, reset behaviour and invariants for several prescales
module tb_gpio_led_module;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] o10, o1, o7;
    int n = 0;
    int checks = 0;
    int errors = 0;
    bit mon = 1'b0;

    always #5 clk = ~clk;

    gpio_led_module #(.PRESCALE(10)) u10 (.clk(clk), .rst(rst), .led1(o10[0]), .led2(o10[1]),
        .led3(o10[2]), .led4(o10[3]), .led_done(o10[4]));
    gpio_led_module #(.PRESCALE(1)) u1 (.clk(clk), .rst(rst), .led1(o1[0]), .led2(o1[1]),
        .led3(o1[2]), .led4(o1[3]), .led_done(o1[4]));
    gpio_led_module #(.PRESCALE(7)) u7 (.clk(clk), .rst(rst), .led1(o7[0]), .led2(o7[1]),
        .led3(o7[2]), .led4(o7[3]), .led_done(o7[4]));

    // edges seen since the last reset release
    always @(posedge clk or posedge rst)
        if (rst) n <= 0;
        else n <= n + 1;

    // expected {done,led4..led1} after n edges: one stage per p edges, five stages total
    function automatic logic [4:0] model(int edges, int p);
        int stage;
        logic [4:0] v;
        stage = edges / p;
        if (stage > 5) stage = 5;
        v = '0;
        for (int k = 1; k <= 4; k++) v[k-1] = stage >= k;
        v[4] = stage == 5;
        return v;
    endfunction

    function automatic bit thermo_ok(logic [4:0] v);
        return v[1] <= v[0] && v[2] <= v[1] && v[3] <= v[2] && (!v[4] || &v[3:0]);
    endfunction

    task automatic check(string name, logic [4:0] got, logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%b exp=%b", name, n, got, exp);
        end
    endtask

    // every-cycle comparison of all instances against the model plus invariants
    always @(negedge clk)
        if (mon) begin
            check("mon_p10", o10, model(n, 10));
            check("mon_p1", o1, model(n, 1));
            check("mon_p7", o7, model(n, 7));
            check("thermo_p10", {4'b0, thermo_ok(o10)}, 5'd1);
            check("thermo_p7", {4'b0, thermo_ok(o7)}, 5'd1);
        end

    typedef struct {
        int edge_n;
        logic [4:0] e10;
        logic [4:0] e1;
    } vec_t;
    vec_t vecs[13];

    task automatic wait_edges(int target);
        for (int i = 0; i < 2000 && n < target; i++) @(negedge clk);
        if (n != target) begin
            errors++;
            $display("FAIL wait_edges target=%0d reached=%0d", target, n);
        end
    endtask

    initial begin
        vecs[0]  = '{1,   5'b00000, 5'b00001};
        vecs[1]  = '{2,   5'b00000, 5'b00011};
        vecs[2]  = '{5,   5'b00000, 5'b11111};
        vecs[3]  = '{9,   5'b00000, 5'b11111};
        vecs[4]  = '{10,  5'b00001, 5'b11111};
        vecs[5]  = '{19,  5'b00001, 5'b11111};
        vecs[6]  = '{20,  5'b00011, 5'b11111};
        vecs[7]  = '{30,  5'b00111, 5'b11111};
        vecs[8]  = '{39,  5'b00111, 5'b11111};
        vecs[9]  = '{40,  5'b01111, 5'b11111};
        vecs[10] = '{49,  5'b01111, 5'b11111};
        vecs[11] = '{50,  5'b11111, 5'b11111};
        vecs[12] = '{250, 5'b11111, 5'b11111};

        repeat (2) @(negedge clk);
        check("reset_p10", o10, 5'b0);
        check("reset_p1", o1, 5'b0);
        check("reset_p7", o7, 5'b0);

        // main sequence: release between edges, then walk the table
        rst = 1'b0;
        mon = 1'b1;
        foreach (vecs[i]) begin
            wait_edges(vecs[i].edge_n);
            check($sformatf("vec_p10_e%0d", vecs[i].edge_n), o10, vecs[i].e10);
            check($sformatf("vec_p1_e%0d", vecs[i].edge_n), o1, vecs[i].e1);
        end

        // async reset in DONE: outputs clear with no clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_done_p10", o10, 5'b0);
        check("async_done_p1", o1, 5'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // mid-sequence reset at edge 25, then full restart
        wait_edges(25);
        check("mid_e25", o10, 5'b00011);
        #2 rst = 1'b1;
        #1;
        check("mid_async", o10, 5'b0);
        repeat (2) @(negedge clk);
        check("mid_held", o10, 5'b0);
        #2 rst = 1'b0;
        wait_edges(9);
        check("restart_e9", o10, 5'b0);
        wait_edges(10);
        check("restart_e10", o10, 5'b00001);
        wait_edges(50);
        check("restart_e50", o10, 5'b11111);

        // random reset pulses at random points within the cycle
        for (int r = 0; r < 25; r++) begin
            @(posedge clk);
            #($urandom_range(1, 4)) rst = 1'b1;
            #1;
            check("rand_async", o10 | o1 | o7, 5'b0);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #($urandom_range(1, 4)) rst = 1'b0;
            repeat ($urandom_range(1, 70)) @(posedge clk);
        end
        @(negedge clk);
        mon = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpio_led_module.md
Name: gpio_led_module

Overview:
- Self-timed LED status sequencer for the accelerator's GPIO/LED panel; has no data inputs, only clock and reset.
- After reset release it lights four progress LEDs one at a time in thermometer order (led1 first, led4 last), then raises led_done.
- It stays in the done state until the next reset.
- It gives a board-level visual check that the clock and reset network are alive and the design is running.

Parameters:
- PRESCALE, 10, clock cycles per sequencer tick; legal range 1..2^16; counter width is $clog2(PRESCALE), minimum 1 bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- led1  output  1  progress LED 1 (stage 1 reached).
- led2  output  1  progress LED 2 (stage 2 reached).
- led3  output  1  progress LED 3 (stage 3 reached).
- led4  output  1  progress LED 4 (stage 4 reached).
- led_done  output  1  sequence complete.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- While rst=1: prescaler counter=0, FSM=S_IDLE, and all five outputs are 0 immediately, independent of clk.
- Reset applies equally mid-sequence and in S_DONE; the next sequence restarts from S_IDLE.
- Prescaler:
  - Counter cnt counts 0..PRESCALE-1, incrementing every clock edge after reset release.
  - It wraps to 0 after PRESCALE-1.
  - tick is a combinational one-cycle pulse, asserted when cnt==PRESCALE-1.
  - PRESCALE=1 means tick is high every cycle.
- FSM states, in order: S_IDLE, S_L1, S_L2, S_L3, S_L4, S_DONE.
  - On a rising edge with tick=1, the state advances one step.
  - S_DONE is terminal; it ignores tick and keeps the prescaler free-running.
  - With tick=0 the state holds.
  - The FSM has no other transitions. Illegal or unused encodings go to S_IDLE on the next edge.
- Output decode, registered (outputs change only on clock edges or on async reset, glitch-free):
  - led1=1 in S_L1 and later.
  - led2=1 in S_L2 and later.
  - led3=1 in S_L3 and later.
  - led4=1 in S_L4 and later.
  - led_done=1 only in S_DONE.
- Timing: count rising edges after rst falls, the first edge with rst=0 being edge 1.
  - led(k) rises at edge k*PRESCALE; led_done rises at edge 5*PRESCALE.
  - Default PRESCALE=10: led1 @10, led2 @20, led3 @30, led4 @40, led_done @50.
  - All stay 1 thereafter.
- Invariants:
  - LEDs are monotonic (thermometer): led(k+1)=1 implies led(k)=1.
  - led_done=1 implies all four LEDs are 1.
  - Once set, no output falls until reset.
- Simultaneous events: rst takes priority over tick at all times.

Test Plan:
- Reset check: hold rst=1 for 1 cycle, toggling clk at 10 ns period -> all five outputs 0. Assert rst asynchronously between clock edges -> outputs go 0 without waiting for an edge.
- Sequence timing (PRESCALE=10): release rst and count edges -> led1 rises exactly at edge 10, led2 @20, led3 @30, led4 @40, led_done @50; at edge 9 all outputs are still 0.
- Steady state: rst high 10 ns, then run 1000 ns (about 100 edges) -> led1..led4 = 1,1,1,1 and led_done=1; they stay constant through an additional 200 cycles.
- Thermometer invariant: sample every cycle during the sequence -> never led(k+1)=1 with led(k)=0, never led_done=1 with any LED 0, no output falls.
- Reset mid-operation: assert rst at edge 25 (led1, led2 = 1) for 2 cycles, then release -> all outputs 0 during reset; led1 rises again at edge 10 after the new release; full sequence repeats.
- PRESCALE=1 instance: release rst -> led1 @1, led2 @2, led3 @3, led4 @4, led_done @5; holds afterwards.
